// File: rtl/eth_irq_pkg.sv
// Shared types for the Ethernet-side interrupt controllers.
package eth_irq_pkg;

  // Throttle FSM: wait for pending, drive the line, then enforce the gap.
  typedef enum logic [1:0] {
    eIdle    = 2'd0,
    eActive  = 2'd1,
    eHoldoff = 2'd2
  } irq_throttle_state_e;

endpackage : eth_irq_pkg

// File: rtl/irq_src_cell.sv
// One interrupt source: either a live level or a sticky rising-edge detector.
module irq_src_cell #(
  parameter bit edge_p     = 1'b0,  // 1: rising-edge/sticky, 0: level
  parameter bit prev_rst_p = 1'b0   // reset value of the previous-sample flop
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic src_i,
  input  logic clear_i,
  output logic raw_pending_o
);

  if (edge_p) begin : g_edge
    logic r_prev;
    logic r_sticky;
    logic w_set;

    assign w_set = ~r_prev & src_i;

    // Previous-sample register for rising-edge detection.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
      if (reset_i) r_prev <= prev_rst_p;
      else         r_prev <= src_i;
    end

    // Sticky pending: a new edge beats a same-cycle clear so no event is lost.
    always_ff @(posedge clk_i) begin
      if (reset_i)      r_sticky <= 1'b0;
      else if (w_set)   r_sticky <= 1'b1;
      else if (clear_i) r_sticky <= 1'b0;
    end

    assign raw_pending_o = r_sticky;
  end else begin : g_level
    // The owner clears a level source at the source itself; clear has no effect here.
    logic w_unused_clear;
    assign w_unused_clear = clear_i;
    assign raw_pending_o  = src_i;
  end

endmodule : irq_src_cell

// File: rtl/interrupt_controller_multi.sv
// N-source interrupt controller: per-source enable, OR aggregation and a
// programmable hold-off that guarantees a minimum gap between irq_o pulses.
module interrupt_controller_multi
  import eth_irq_pkg::*;
#(
  parameter int                         num_src_p       = 2,
  parameter logic [num_src_p-1:0]       edge_mask_p     = '0,
  parameter logic [num_src_p-1:0]       edge_prev_rst_p = '0,
  parameter int                         holdoff_width_p = 16,
  parameter logic [holdoff_width_p-1:0] holdoff_reset_p = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [num_src_p-1:0]       src_i,
  input  logic [num_src_p-1:0]       clear_i,
  input  logic [num_src_p-1:0]       enable_data_i,
  input  logic                       enable_v_i,
  input  logic [holdoff_width_p-1:0] holdoff_data_i,
  input  logic                       holdoff_v_i,
  output logic [num_src_p-1:0]       raw_pending_o,
  output logic [num_src_p-1:0]       pending_o,
  output logic                       irq_o
);

  localparam logic [holdoff_width_p-1:0] cnt_one = holdoff_width_p'(1);

  logic [num_src_p-1:0]       w_raw_pending;
  logic [num_src_p-1:0]       r_enable;
  logic [holdoff_width_p-1:0] r_holdoff;
  logic [holdoff_width_p-1:0] r_cnt;
  irq_throttle_state_e        r_state;
  logic                       r_irq;
  logic                       w_any;

  for (genvar gi = 0; gi < num_src_p; gi++) begin : g_src
    irq_src_cell #(
      .edge_p     (edge_mask_p[gi]),
      .prev_rst_p (edge_prev_rst_p[gi])
    ) u_cell (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .src_i         (src_i[gi]),
      .clear_i       (clear_i[gi]),
      .raw_pending_o (w_raw_pending[gi])
    );
  end

  // Enable mask register; a disabled source keeps its pending state.
  always_ff @(posedge clk_i) begin
    if (reset_i)         r_enable <= '0;
    else if (enable_v_i) r_enable <= enable_data_i;
  end

  // Hold-off length register; only sampled when the counter is loaded.
  always_ff @(posedge clk_i) begin
    if (reset_i)          r_holdoff <= holdoff_reset_p;
    else if (holdoff_v_i) r_holdoff <= holdoff_data_i;
  end

  assign raw_pending_o = w_raw_pending;
  assign pending_o     = w_raw_pending & r_enable;
  assign w_any         = |pending_o;

  // Throttle FSM with registered irq and hold-off down-counter.
  // The counter is only loaded with a non-zero value and leaves at 1, so it never wraps.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIdle;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
    end else begin
      case (r_state)
        eIdle: begin
          if (w_any) begin
            r_state <= eActive;
            r_irq   <= 1'b1;
          end
        end
        eActive: begin
          if (!w_any) begin
            r_irq <= 1'b0;
            if (r_holdoff == '0) begin
              r_state <= eIdle;
            end else begin
              r_cnt   <= r_holdoff;
              r_state <= eHoldoff;
            end
          end
        end
        eHoldoff: begin
          r_cnt <= r_cnt - cnt_one;
          if (r_cnt == cnt_one) r_state <= eIdle;
        end
        default: begin
          r_state <= eIdle;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o = r_irq;

endmodule : interrupt_controller_multi

// File: tb/tb_interrupt_controller_multi.sv
// Directed bench: source 0 is a level source, source 1 a rising-edge source
// whose previous-sample flop resets high.
module tb_interrupt_controller_multi;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [1:0]  src_i;
  logic [1:0]  clear_i;
  logic [1:0]  enable_data_i;
  logic        enable_v_i;
  logic [15:0] holdoff_data_i;
  logic        holdoff_v_i;
  logic [1:0]  raw_pending_o;
  logic [1:0]  pending_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  interrupt_controller_multi #(
    .num_src_p       (2),
    .edge_mask_p     (2'b10),
    .edge_prev_rst_p (2'b10),
    .holdoff_width_p (16),
    .holdoff_reset_p (16'd0)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .src_i          (src_i),
    .clear_i        (clear_i),
    .enable_data_i  (enable_data_i),
    .enable_v_i     (enable_v_i),
    .holdoff_data_i (holdoff_data_i),
    .holdoff_v_i    (holdoff_v_i),
    .raw_pending_o  (raw_pending_o),
    .pending_o      (pending_o),
    .irq_o          (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge; inputs are driven and
  // outputs sampled here, well away from the edge.
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic write_enable(input logic [1:0] m);
    enable_data_i = m;
    enable_v_i    = 1'b1;
    cyc();
    enable_v_i    = 1'b0;
  endtask

  task automatic write_holdoff(input logic [15:0] h);
    holdoff_data_i = h;
    holdoff_v_i    = 1'b1;
    cyc();
    holdoff_v_i    = 1'b0;
  endtask

  // Counts irq_o-low cycles (including the current one) until irq_o rises.
  task automatic count_low(input string name, input int expected);
    int lows;
    bit seen;
    lows = 1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (irq_o) begin
        seen = 1'b1;
        break;
      end
      lows++;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s: irq_o never reasserted within 40 cycles, expected gap %0d", name, expected);
    end else if (lows !== expected) begin
      n_bad++;
      $display("FAIL %s: low cycles=%0d expected=%0d", name, lows, expected);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    src_i   = 2'b10;
    repeat (3) cyc();
    reset_i = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b expected 0", irq_o); end
    n_cmp++;
    if (pending_o !== 2'b00) begin n_bad++; $display("FAIL reset_pending: got %b expected 00", pending_o); end
    cyc();
    cyc();
    n_cmp++;
    if (raw_pending_o !== 2'b00) begin n_bad++; $display("FAIL reset_no_spurious_edge: raw=%b expected 00", raw_pending_o); end
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_irq_idle: got %b expected 0", irq_o); end
    // Level source visible raw, but masked while enable is still zero.
    src_i = 2'b01;
    #1;
    n_cmp++;
    if (raw_pending_o !== 2'b01 || pending_o !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_enable_zero: raw=%b pend=%b expected raw=01 pend=00", raw_pending_o, pending_o);
    end
    cyc();
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL reset_masked_irq: got %b expected 0", irq_o); end
    src_i = 2'b00;
    cyc();
  endtask

  task automatic test_level();
    write_enable(2'b01);
    src_i[0] = 1'b1;
    #1;
    n_cmp++;
    if (pending_o !== 2'b01) begin n_bad++; $display("FAIL level_pending: got %b expected 01", pending_o); end
    cyc();
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL level_irq_t1: got %b expected 1", irq_o); end
    cyc();
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL level_irq_hold: got %b expected 1", irq_o); end
    src_i[0] = 1'b0;
    cyc();
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL level_irq_drop: got %b expected 0", irq_o); end
    cyc();
  endtask

  task automatic test_edge();
    write_enable(2'b10);
    src_i = 2'b10;
    cyc();
    n_cmp++;
    if (raw_pending_o !== 2'b10 || irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL edge_t1: raw=%b irq=%b expected raw=10 irq=0", raw_pending_o, irq_o);
    end
    cyc();
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL edge_irq_t2: got %b expected 1", irq_o); end
    src_i = 2'b00;
    cyc();
    n_cmp++;
    if (raw_pending_o !== 2'b10 || irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_sticky: raw=%b irq=%b expected raw=10 irq=1", raw_pending_o, irq_o);
    end
    clear_i = 2'b10;
    cyc();
    clear_i = 2'b00;
    n_cmp++;
    if (raw_pending_o !== 2'b00 || irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL edge_clear_v1: raw=%b irq=%b expected raw=00 irq=1", raw_pending_o, irq_o);
    end
    cyc();
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL edge_clear_v2: got %b expected 0", irq_o); end
  endtask

  task automatic test_set_wins();
    src_i   = 2'b10;
    clear_i = 2'b10;
    cyc();
    clear_i = 2'b00;
    n_cmp++;
    if (raw_pending_o[1] !== 1'b1) begin n_bad++; $display("FAIL set_wins: raw[1]=%b expected 1", raw_pending_o[1]); end
    // Clear it while the source stays high: no new edge, so it stays cleared.
    clear_i = 2'b10;
    cyc();
    clear_i = 2'b00;
    cyc();
    n_cmp++;
    if (raw_pending_o !== 2'b00) begin n_bad++; $display("FAIL edge_no_reedge: raw=%b expected 00", raw_pending_o); end
    src_i = 2'b01;
    clear_i = 2'b01;
    cyc();
    clear_i = 2'b00;
    n_cmp++;
    if (raw_pending_o !== 2'b01) begin n_bad++; $display("FAIL level_clear_ignored: raw=%b expected 01", raw_pending_o); end
    src_i = 2'b00;
    repeat (3) cyc();
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL set_wins_settle: irq=%b expected 0", irq_o); end
  endtask

  task automatic test_holdoff();
    write_holdoff(16'd5);
    write_enable(2'b01);
    src_i[0] = 1'b1;
    cyc();
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL holdoff_first_irq: got %b expected 1", irq_o); end
    src_i[0] = 1'b0;
    cyc();
    n_cmp++;
    if (irq_o !== 1'b0) begin n_bad++; $display("FAIL holdoff_drop: got %b expected 0", irq_o); end
    src_i[0] = 1'b1;
    count_low("holdoff_gap5", 6);
    // A hold-off write during the throttle window must not disturb the running count.
    src_i[0] = 1'b0;
    cyc();
    holdoff_data_i = 16'd2;
    holdoff_v_i    = 1'b1;
    src_i[0]       = 1'b1;
    cyc();
    holdoff_v_i    = 1'b0;
    count_low("holdoff_write_during_run", 5);
    src_i[0] = 1'b0;
    cyc();
    src_i[0] = 1'b1;
    count_low("holdoff_gap2", 3);
    src_i[0] = 1'b0;
    repeat (4) cyc();
  endtask

  task automatic test_reset_mid();
    write_holdoff(16'd5);
    write_enable(2'b11);
    src_i = 2'b01;
    cyc();
    src_i = 2'b10;
    cyc();
    n_cmp++;
    if (irq_o !== 1'b0 || pending_o !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_mid_setup: irq=%b pend=%b expected irq=0 pend=10", irq_o, pending_o);
    end
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    n_cmp++;
    if (irq_o !== 1'b0 || pending_o !== 2'b00 || raw_pending_o !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_mid_state: irq=%b pend=%b raw=%b expected 0/00/00", irq_o, pending_o, raw_pending_o);
    end
    // From eIdle a new pending must raise irq_o without any leftover hold-off.
    enable_data_i = 2'b01;
    enable_v_i    = 1'b1;
    src_i         = 2'b11;
    cyc();
    enable_v_i    = 1'b0;
    cyc();
    n_cmp++;
    if (irq_o !== 1'b1) begin n_bad++; $display("FAIL reset_mid_fsm_idle: irq=%b expected 1", irq_o); end
    src_i = 2'b00;
    cyc();
  endtask

  initial begin
    reset_i        = 1'b1;
    src_i          = 2'b10;
    clear_i        = 2'b00;
    enable_data_i  = 2'b00;
    enable_v_i     = 1'b0;
    holdoff_data_i = 16'd0;
    holdoff_v_i    = 1'b0;
    test_reset();
    test_level();
    test_edge();
    test_set_wins();
    test_holdoff();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_interrupt_controller_multi
